// File: rtl/dcache_ctrl.sv
// dcache_ctrl: per-request sequencer between the CPU load/store port and one
// dcache_line. Latches a CPU read or write, issues it to the line, runs a
// refill on a miss (fill pulse, count memory beats) and replays the request
// once. Returns load data plus a completion or error pulse to the CPU.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   cpu_addr/datain/be          CPU request payload
//   cpu_rdreq/cpu_wrreq         CPU request pulses (ignored while cpu_busy)
//   cpu_dataout                 last load data
//   cpu_valid/cpu_err           one-cycle completion / error pulses
//   cpu_busy                    request in flight
//   dcache_addr/datain/be       latched request payload to the line
//   dcache_rdreq/dcache_wrreq   one-cycle request pulses to the line
//   line_out/valid/miss         line response
//   line_fill                   one-cycle refill command
//   mem_valid, mem_burstlen     memory beat strobe and refill burst length
module dcache_ctrl #(
  parameter int unsigned ADDRBITS     = 32,
  parameter int unsigned DATABITS     = 32,
  parameter int unsigned BANKNUM      = 4,
  parameter int unsigned RESP_TIMEOUT = 16,
  parameter int unsigned FILL_TIMEOUT = 4096
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDRBITS-1:0] cpu_addr,
  input  logic [DATABITS-1:0] cpu_datain,
  input  logic                cpu_rdreq,
  input  logic                cpu_wrreq,
  input  logic [BANKNUM-1:0]  cpu_be,
  output logic [DATABITS-1:0] cpu_dataout,
  output logic                cpu_valid,
  output logic                cpu_err,
  output logic                cpu_busy,
  output logic [ADDRBITS-1:0] dcache_addr,
  output logic [DATABITS-1:0] dcache_datain,
  output logic [BANKNUM-1:0]  dcache_be,
  output logic                dcache_rdreq,
  output logic                dcache_wrreq,
  input  logic [DATABITS-1:0] line_out,
  input  logic                line_valid,
  input  logic                line_miss,
  output logic                line_fill,
  input  logic                mem_valid,
  input  logic [15:0]         mem_burstlen
);

  localparam int unsigned TMO_MAX = (RESP_TIMEOUT > FILL_TIMEOUT) ? RESP_TIMEOUT : FILL_TIMEOUT;
  localparam int unsigned TMOW    = $clog2(TMO_MAX + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOOKUP = 2'd1;
  localparam logic [1:0] ST_FILL   = 2'd2;
  localparam logic [1:0] ST_REPLAY = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [ADDRBITS-1:0] addr_q, addr_d;
  logic [DATABITS-1:0] data_q, data_d;
  logic [BANKNUM-1:0]  be_q, be_d;
  logic                is_wr_q, is_wr_d;
  logic                retry_q, retry_d;
  logic [TMOW-1:0]     tmo_q, tmo_d;
  logic [15:0]         beat_q, beat_d;
  logic [15:0]         blen_q, blen_d;
  logic [DATABITS-1:0] dout_q, dout_d;
  logic                rdreq_q, rdreq_d;
  logic                wrreq_q, wrreq_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic                fill_q, fill_d;
  logic                busy_q, busy_d;
  logic [15:0]         beat_inc_c;

  assign beat_inc_c = beat_q + 16'd1;

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    be_d    = be_q;
    is_wr_d = is_wr_q;
    retry_d = retry_q;
    tmo_d   = tmo_q;
    beat_d  = beat_q;
    blen_d  = blen_q;
    dout_d  = dout_q;
    rdreq_d = 1'b0;
    wrreq_d = 1'b0;
    valid_d = 1'b0;
    err_d   = 1'b0;
    fill_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cpu_rdreq || cpu_wrreq) begin
          addr_d  = cpu_addr;
          data_d  = cpu_datain;
          be_d    = cpu_be;
          // A simultaneous read and write keeps the read only.
          is_wr_d = !cpu_rdreq;
          rdreq_d = cpu_rdreq;
          wrreq_d = !cpu_rdreq;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        tmo_d = tmo_q + TMOW'(1);
        if (line_valid) begin
          if (!is_wr_q) dout_d = line_out;
          valid_d = 1'b1;
          state_d = ST_IDLE;
        end else if (line_miss) begin
          if (retry_q) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            fill_d  = 1'b1;
            blen_d  = (mem_burstlen == 16'd0) ? 16'd1 : mem_burstlen;
            beat_d  = 16'd0;
            tmo_d   = '0;
            state_d = ST_FILL;
          end
        end else if (tmo_q == TMOW'(RESP_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_FILL: begin
        tmo_d = tmo_q + TMOW'(1);
        if (mem_valid) beat_d = beat_inc_c;
        // Replay pulse is launched together with the move to REPLAY so it
        // appears the cycle after the final beat.
        if (mem_valid && (beat_inc_c == blen_q)) begin
          retry_d = 1'b1;
          rdreq_d = !is_wr_q;
          wrreq_d = is_wr_q;
          state_d = ST_REPLAY;
        end else if (tmo_q == TMOW'(FILL_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_REPLAY: begin
        tmo_d   = '0;
        state_d = ST_LOOKUP;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_IDLE) begin
      retry_d = 1'b0;
      tmo_d   = '0;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      be_q    <= '0;
      is_wr_q <= 1'b0;
      retry_q <= 1'b0;
      tmo_q   <= '0;
      beat_q  <= '0;
      blen_q  <= '0;
      dout_q  <= '0;
      rdreq_q <= 1'b0;
      wrreq_q <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      fill_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      be_q    <= be_d;
      is_wr_q <= is_wr_d;
      retry_q <= retry_d;
      tmo_q   <= tmo_d;
      beat_q  <= beat_d;
      blen_q  <= blen_d;
      dout_q  <= dout_d;
      rdreq_q <= rdreq_d;
      wrreq_q <= wrreq_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      fill_q  <= fill_d;
      busy_q  <= busy_d;
    end
  end

  assign cpu_dataout   = dout_q;
  assign cpu_valid     = valid_q;
  assign cpu_err       = err_q;
  assign cpu_busy      = busy_q;
  assign dcache_addr   = addr_q;
  assign dcache_datain = data_q;
  assign dcache_be     = be_q;
  assign dcache_rdreq  = rdreq_q;
  assign dcache_wrreq  = wrreq_q;
  assign line_fill     = fill_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Testbench for dcache_ctrl: table-driven single-cycle vectors plus directed
// sequences for refill, replay, double miss, timeouts and reset mid-fill.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_addr, cpu_datain, line_out;
  logic        cpu_rdreq, cpu_wrreq, line_valid, line_miss, mem_valid;
  logic [3:0]  cpu_be;
  logic [15:0] mem_burstlen;

  logic [31:0] cpu_dataout, dcache_addr, dcache_datain;
  logic        cpu_valid, cpu_err, cpu_busy, dcache_rdreq, dcache_wrreq, line_fill;
  logic [3:0]  dcache_be;

  logic [31:0] d16_dataout, d16_addr, d16_datain;
  logic        d16_valid, d16_err, d16_busy, d16_rdreq, d16_wrreq, d16_fill;
  logic [3:0]  d16_be;

  always #5 clk = ~clk;

  dcache_ctrl u_dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_datain(cpu_datain), .cpu_rdreq(cpu_rdreq),
    .cpu_wrreq(cpu_wrreq), .cpu_be(cpu_be), .cpu_dataout(cpu_dataout),
    .cpu_valid(cpu_valid), .cpu_err(cpu_err), .cpu_busy(cpu_busy),
    .dcache_addr(dcache_addr), .dcache_datain(dcache_datain), .dcache_be(dcache_be),
    .dcache_rdreq(dcache_rdreq), .dcache_wrreq(dcache_wrreq),
    .line_out(line_out), .line_valid(line_valid), .line_miss(line_miss),
    .line_fill(line_fill), .mem_valid(mem_valid), .mem_burstlen(mem_burstlen)
  );

  // Short-timeout instance sharing all inputs, used for the fill abort.
  dcache_ctrl #(.RESP_TIMEOUT(16), .FILL_TIMEOUT(16)) u_dut16 (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_datain(cpu_datain), .cpu_rdreq(cpu_rdreq),
    .cpu_wrreq(cpu_wrreq), .cpu_be(cpu_be), .cpu_dataout(d16_dataout),
    .cpu_valid(d16_valid), .cpu_err(d16_err), .cpu_busy(d16_busy),
    .dcache_addr(d16_addr), .dcache_datain(d16_datain), .dcache_be(d16_be),
    .dcache_rdreq(d16_rdreq), .dcache_wrreq(d16_wrreq),
    .line_out(line_out), .line_valid(line_valid), .line_miss(line_miss),
    .line_fill(d16_fill), .mem_valid(mem_valid), .mem_burstlen(mem_burstlen)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_fill = 0, n_drd = 0, n_dwr = 0, n_valid = 0, n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counters for the main instance.
  always @(negedge clk) begin
    if (!reset) begin
      if (line_fill)    n_fill  = n_fill + 1;
      if (dcache_rdreq) n_drd   = n_drd + 1;
      if (dcache_wrreq) n_dwr   = n_dwr + 1;
      if (cpu_valid)    n_valid = n_valid + 1;
      if (cpu_err)      n_err   = n_err + 1;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Inputs applied in a cycle and the registered outputs expected in that
  // same cycle (i.e. produced by the previous cycle's inputs).
  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic        lv;
    logic [31:0] lo;
    logic [5:0]  ctl;   // {drd, dwr, busy, valid, err, fill}
    logic [31:0] dout;
    logic [31:0] daddr;
  } vec_t;

  function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] a,
                              input logic lv, input logic [31:0] lo, input logic [5:0] ctl,
                              input logic [31:0] dout, input logic [31:0] ea);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = a; v.lv = lv; v.lo = lo;
    v.ctl = ctl; v.dout = dout; v.daddr = ea;
    return v;
  endfunction

  vec_t vecs[19];

  initial begin
    int s_fill, s_drd, s_dwr, s_valid, s_err, last_beat, early, lowbusy;

    reset = 1'b1;
    cpu_addr = '0; cpu_datain = '0; cpu_rdreq = 0; cpu_wrreq = 0; cpu_be = '0;
    line_out = '0; line_valid = 0; line_miss = 0; mem_valid = 0; mem_burstlen = '0;

    vecs[0]  = mk(1, 0, 32'hd00faffc, 0, 0,            6'b000000, 32'h0,   32'h0);
    vecs[1]  = mk(0, 0, 0,            0, 0,            6'b101000, 32'h0,   32'hd00faffc);
    vecs[2]  = mk(0, 0, 0,            1, 32'h103,      6'b001000, 32'h0,   32'hd00faffc);
    vecs[3]  = mk(0, 0, 0,            0, 0,            6'b000100, 32'h103, 32'hd00faffc);
    vecs[4]  = mk(0, 0, 0,            0, 0,            6'b000000, 32'h103, 32'hd00faffc);
    vecs[5]  = mk(1, 1, 32'h40,       0, 0,            6'b000000, 32'h103, 32'hd00faffc);
    vecs[6]  = mk(0, 0, 0,            0, 0,            6'b101000, 32'h103, 32'h40);
    vecs[7]  = mk(0, 0, 0,            1, 32'h55,       6'b001000, 32'h103, 32'h40);
    vecs[8]  = mk(0, 0, 0,            0, 0,            6'b000100, 32'h55,  32'h40);
    vecs[9]  = mk(0, 1, 32'h80,       0, 0,            6'b000000, 32'h55,  32'h40);
    vecs[10] = mk(0, 0, 0,            0, 0,            6'b011000, 32'h55,  32'h80);
    vecs[11] = mk(0, 0, 0,            1, 32'hffffffff, 6'b001000, 32'h55,  32'h80);
    vecs[12] = mk(0, 0, 0,            0, 0,            6'b000100, 32'h55,  32'h80);
    vecs[13] = mk(1, 0, 32'h100,      0, 0,            6'b000000, 32'h55,  32'h80);
    vecs[14] = mk(1, 0, 32'h200,      0, 0,            6'b101000, 32'h55,  32'h100);
    vecs[15] = mk(0, 1, 32'h200,      0, 0,            6'b001000, 32'h55,  32'h100);
    vecs[16] = mk(0, 0, 0,            1, 32'h7,        6'b001000, 32'h55,  32'h100);
    vecs[17] = mk(0, 0, 0,            0, 0,            6'b000100, 32'h7,   32'h100);
    vecs[18] = mk(0, 0, 0,            0, 0,            6'b000000, 32'h7,   32'h100);

    tick(); tick();
    chk("reset_state", {cpu_dataout, cpu_valid, cpu_err, cpu_busy, dcache_addr, dcache_datain,
                        dcache_be, dcache_rdreq, dcache_wrreq, line_fill}, '0);
    chk("reset_state16", {d16_dataout, d16_valid, d16_err, d16_busy, d16_addr, d16_datain,
                          d16_be, d16_rdreq, d16_wrreq, d16_fill}, '0);
    reset = 1'b0;

    // Hit, simultaneous read/write, write hit, requests while busy.
    for (int i = 0; i < 19; i++) begin
      chk($sformatf("vec%0d", i),
          {dcache_rdreq, dcache_wrreq, cpu_busy, cpu_valid, cpu_err, line_fill, cpu_dataout, dcache_addr},
          {vecs[i].ctl, vecs[i].dout, vecs[i].daddr});
      cpu_rdreq = vecs[i].rd; cpu_wrreq = vecs[i].wr; cpu_addr = vecs[i].addr;
      line_valid = vecs[i].lv; line_out = vecs[i].lo;
      tick();
    end
    cpu_rdreq = 0; cpu_wrreq = 0; line_valid = 0;

    // Lookup timeout: error 16 cycles after the issue pulse.
    cpu_rdreq = 1; cpu_addr = 32'h500; tick(); cpu_rdreq = 0;
    chk("tmo_issue", dcache_rdreq, 1'b1);
    early = 0; lowbusy = 0;
    for (int k = 1; k <= 16; k++) begin
      if (cpu_err) early++;
      if (!cpu_busy) lowbusy++;
      tick();
    end
    chk("tmo_no_early_err", early, 0);
    chk("tmo_busy_held", lowbusy, 0);
    chk("tmo_err", {cpu_err, cpu_busy}, 2'b10);
    tick();
    chk("tmo_err_one_cycle", cpu_err, 1'b0);

    // Read miss with 32-beat refill and a gap after the third beat.
    s_fill = n_fill; s_drd = n_drd; s_valid = n_valid; s_err = n_err;
    cpu_rdreq = 1; cpu_addr = 32'hd00faffc; tick(); cpu_rdreq = 0;
    tick(); line_miss = 1; mem_burstlen = 16'd32;
    tick(); line_miss = 0;
    chk("miss_fill_pulse", line_fill, 1'b1);
    tick();
    last_beat = 0;
    for (int n = 1; n <= 32; n++) begin
      mem_valid = 1; line_out = 32'h100 + 32'(n - 1);
      if (n == 32) last_beat = cyc;
      tick(); mem_valid = 0;
      if (n == 3) tick();
    end
    chk("miss_replay_cycle", {dcache_rdreq, 32'(cyc - last_beat)}, {1'b1, 32'd1});
    tick(); line_valid = 1; line_out = 32'hdeadbeef;
    tick(); line_valid = 0;
    chk("miss_done", {cpu_valid, cpu_busy, cpu_dataout}, {2'b10, 32'hdeadbeef});
    tick();
    chk("miss_counts", {32'(n_fill - s_fill), 32'(n_drd - s_drd), 32'(n_valid - s_valid), 32'(n_err - s_err)},
        {32'd1, 32'd2, 32'd1, 32'd0});

    // Write miss: replay carries the originally latched payload.
    s_fill = n_fill; s_dwr = n_dwr;
    cpu_wrreq = 1; cpu_addr = 32'hcccccccc; cpu_datain = 32'hdeadbeef; cpu_be = 4'b0011;
    tick(); cpu_wrreq = 0; cpu_addr = 32'h0; cpu_datain = 32'h0; cpu_be = 4'hf;
    chk("wmiss_issue", dcache_wrreq, 1'b1);
    tick(); line_miss = 1; mem_burstlen = 16'd2;
    tick(); line_miss = 0; mem_valid = 1;
    tick();
    tick(); mem_valid = 0;
    chk("wmiss_replay", {dcache_wrreq, dcache_rdreq, dcache_addr, dcache_datain, dcache_be},
        {2'b10, 32'hcccccccc, 32'hdeadbeef, 4'b0011});
    tick(); line_valid = 1; line_out = 32'h12345678;
    tick(); line_valid = 0;
    chk("wmiss_done", {cpu_valid, cpu_busy, cpu_dataout}, {2'b10, 32'hdeadbeef});
    chk("wmiss_counts", {32'(n_fill - s_fill), 32'(n_dwr - s_dwr)}, {32'd1, 32'd2});
    tick();

    // Double miss with burstlen 0 (treated as one beat).
    s_fill = n_fill; s_err = n_err; s_valid = n_valid;
    cpu_rdreq = 1; cpu_addr = 32'h2000; tick(); cpu_rdreq = 0;
    tick(); line_miss = 1; mem_burstlen = 16'd0;
    tick(); line_miss = 0; mem_valid = 1;
    tick(); mem_valid = 0;
    chk("dmiss_replay", dcache_rdreq, 1'b1);
    tick(); line_miss = 1;
    tick(); line_miss = 0;
    chk("dmiss_err", {cpu_err, cpu_busy, cpu_valid, cpu_dataout}, {3'b100, 32'hdeadbeef});
    tick();
    chk("dmiss_counts", {32'(n_fill - s_fill), 32'(n_err - s_err), 32'(n_valid - s_valid)},
        {32'd1, 32'd1, 32'd0});

    // Fill timeout on the short-timeout instance; no beats arrive.
    cpu_rdreq = 1; cpu_addr = 32'h3000; tick(); cpu_rdreq = 0;
    tick(); line_miss = 1; mem_burstlen = 16'd4;
    tick(); line_miss = 0;
    early = 0;
    for (int k = 3; k <= 18; k++) begin
      if (d16_err) early++;
      tick();
    end
    chk("ftmo_no_early_err", early, 0);
    chk("ftmo_err16", {d16_err, d16_busy}, 2'b10);
    chk("ftmo_main_still_filling", {cpu_err, cpu_busy}, 2'b01);

    // Reset asserted at beat 10 of the main instance's fill.
    for (int n = 1; n <= 9; n++) begin
      mem_valid = 1; tick();
    end
    mem_valid = 1;
    chk("busy_before_reset", cpu_busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("reset_mid_fill", {cpu_dataout, cpu_valid, cpu_err, cpu_busy, dcache_addr, dcache_datain,
                           dcache_be, dcache_rdreq, dcache_wrreq, line_fill}, '0);
    chk("reset_mid_fill16", {d16_dataout, d16_valid, d16_err, d16_busy, d16_addr, d16_datain,
                             d16_be, d16_rdreq, d16_wrreq, d16_fill}, '0);
    mem_valid = 0;
    s_valid = n_valid; s_err = n_err; s_fill = n_fill; s_drd = n_drd;
    tick(); tick(); reset = 1'b0;
    tick(); tick();
    chk("no_pulse_after_reset", {32'(n_valid - s_valid), 32'(n_err - s_err)}, 64'd0);

    // Clean hit after reset release.
    cpu_rdreq = 1; cpu_addr = 32'h4000; tick(); cpu_rdreq = 0;
    chk("post_reset_issue", {dcache_rdreq, cpu_busy, dcache_addr}, {2'b11, 32'h4000});
    tick(); line_valid = 1; line_out = 32'h42;
    tick(); line_valid = 0;
    chk("post_reset_hit", {cpu_valid, cpu_busy, cpu_err, cpu_dataout}, {3'b100, 32'h42});
    tick();
    chk("post_reset_counts", {32'(n_fill - s_fill), 32'(n_drd - s_drd)}, {32'd0, 32'd1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
Per-request sequencer between the CPU core load/store port and one dcache_line. It latches a CPU read or write and issues it to the line. On a miss it pulses line_fill, then counts memory beats until the refill burst completes, and replays the request once. It returns read data and completion or error to the CPU, and holds the CPU off with cpu_busy.

Parameters:
ADDRBITS, 32, address width
DATABITS, 32, data width
BANKNUM, 4, byte enables (DATABITS/8)
RESP_TIMEOUT, 16, max cycles to wait for line_valid/line_miss after a request pulse
FILL_TIMEOUT, 4096, max cycles in FILL before abort

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
cpu_addr  in  ADDRBITS  request address
cpu_datain  in  DATABITS  store data
cpu_rdreq  in  1  load request, single-cycle pulse, sampled only when !cpu_busy
cpu_wrreq  in  1  store request, single-cycle pulse, sampled only when !cpu_busy
cpu_be  in  BANKNUM  store byte enables
cpu_dataout  out  DATABITS  load data, held until next load completes
cpu_valid  out  1  one-cycle completion pulse (load or store)
cpu_err  out  1  one-cycle error pulse (timeout or double miss)
cpu_busy  out  1  request in flight
dcache_addr  out  ADDRBITS  latched address to line
dcache_datain  out  DATABITS  latched store data
dcache_be  out  BANKNUM  latched byte enables
dcache_rdreq  out  1  one-cycle read pulse to line
dcache_wrreq  out  1  one-cycle write pulse to line
line_out  in  DATABITS  line read data
line_valid  in  1  line hit/complete
line_miss  in  1  line miss
line_fill  out  1  one-cycle fill command
mem_valid  in  1  memory beat strobe (shared with line)
mem_burstlen  in  16  refill burst length in words

Behaviour:
- Reset (asynchronous, immediate): state IDLE; all outputs 0; beat and timeout counters 0; retry flag 0. Reset asserted mid-fill abandons the request; no cpu_valid or cpu_err is emitted.
- States: IDLE, LOOKUP, FILL, REPLAY.
- IDLE:
  - On cpu_rdreq or cpu_wrreq: latch addr/datain/be/type into dcache_* registers. If both requests are set, the read wins and the write is dropped.
  - Next cycle: dcache_rdreq or dcache_wrreq is 1 for exactly one cycle, cpu_busy=1, state goes to LOOKUP.
- LOOKUP:
  - Timeout counter increments each cycle.
  - line_valid has priority over line_miss.
  - line_valid: a load captures line_out into cpu_dataout. cpu_valid pulses 1 cycle, cpu_busy drops in the same cycle, state returns to IDLE.
  - line_miss with retry=0: line_fill pulses 1 cycle. Sample mem_burstlen (0 is treated as 1), clear the beat counter, go to FILL.
  - line_miss with retry=1: cpu_err pulse, go to IDLE.
  - Counter reaches RESP_TIMEOUT: cpu_err pulse, go to IDLE.
- FILL:
  - Beat counter (16 bit) increments on each mem_valid. Gaps in mem_valid are allowed.
  - When the count equals the sampled burstlen, set retry=1 and go to REPLAY next cycle.
  - FILL_TIMEOUT cycles without completion: cpu_err, go to IDLE.
  - mem_valid outside FILL is ignored.
- REPLAY: reissue the latched request pulse (identical addr/data/be), clear the timeout counter, go to LOOKUP.
- Retry is cleared on every return to IDLE.
- Latency:
  - Hit: request cycle + 1 issue cycle + line response. cpu_valid arrives ≥2 cycles after cpu_rdreq.
  - Miss: hit latency + 1 (fill pulse) + burst duration + 1 (replay) + line response.
- cpu_rdreq/cpu_wrreq while cpu_busy=1 are ignored, with no queueing.
- cpu_dataout is unchanged on stores and errors.

Test Plan:
- Read hit: cpu_rdreq at addr 0xd00faffc, line_valid with line_out=0x00000103 two cycles later -> cpu_dataout=0x103, one cpu_valid pulse, cpu_busy high for exactly the in-between cycles, no line_fill.
- Read miss + refill: line_miss after request, mem_burstlen=32, 32 mem_valid beats (values 0x100..) with one gap cycle after the 3rd beat -> exactly one line_fill pulse, dcache_rdreq reissued exactly 1 cycle after the 32nd beat, then line_valid with 0xdeadbeef -> cpu_dataout=0xdeadbeef, cpu_valid once.
- Write miss: cpu_wrreq, data 0xdeadbeef, be=4'b0011, addr 0xcccccccc -> replayed dcache_wrreq carries identical addr/data/be; cpu_valid after line_valid; cpu_dataout unchanged.
- Double miss: line_miss on both the first lookup and the replay -> one line_fill total, one cpu_err pulse, return to IDLE.
- Timeouts: no line response for 16 cycles -> cpu_err at cycle 16. In FILL, mem_burstlen=0 with a single beat -> completes. With RESP_TIMEOUT and FILL_TIMEOUT both set to 16 and no beats -> cpu_err.
- Simultaneous and reset: cpu_rdreq and cpu_wrreq together -> only dcache_rdreq issued. Reset asserted at beat 10 of a fill -> all outputs 0 immediately; a new read after release behaves as a clean hit.
